// File: rtl/pc_pkg.sv
// Shared types and command decode for the program counter / return stack unit.
package pc_pkg;

  typedef enum logic [2:0] {
    PC_HOLD,
    PC_INC,
    PC_REL,
    PC_LD,
    PC_CALL,
    PC_RET
  } pc_op_e;

  function automatic pc_op_e pc_decode(input logic ret, input logic call,
                                       input logic ld, input logic rel,
                                       input logic pc_enable);
    pc_op_e op;
    op = PC_HOLD;
    if (ret)            op = PC_RET;
    else if (call)      op = PC_CALL;
    else if (ld)        op = PC_LD;
    else if (rel)       op = PC_REL;
    else if (pc_enable) op = PC_INC;
    return op;
  endfunction

endpackage

// File: rtl/pc_ret_stack.sv
// Return-address LIFO; refuses push when full / pop when empty and flags the refusal.
module pc_ret_stack #(
  parameter int ADDR_W      = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 push_i,
  input  logic                                 pop_i,
  input  logic [ADDR_W-1:0]                    push_data_i,
  output logic [ADDR_W-1:0]                    pop_data_o,
  output logic [$clog2(STACK_DEPTH+1)-1:0]     sp_o,
  output logic                                 full_o,
  output logic                                 empty_o,
  output logic                                 err_o
);
  localparam int SP_W = $clog2(STACK_DEPTH+1);

  logic [ADDR_W-1:0] mem_q [STACK_DEPTH];
  logic [SP_W-1:0]   sp_q, sp_d;
  logic              push_ok, pop_ok;

  assign full_o  = (sp_q == SP_W'(STACK_DEPTH));
  assign empty_o = (sp_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign err_o   = (push_i && full_o) || (pop_i && empty_o);
  assign sp_o    = sp_q;

  always_comb begin
    sp_d = sp_q;
    if (push_ok)     sp_d = sp_q + SP_W'(1);
    else if (pop_ok) sp_d = sp_q - SP_W'(1);
  end

  // Top-of-stack is the entry just below sp; zero when empty.
  always_comb begin
    pop_data_o = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (sp_q == SP_W'(i + 1)) pop_data_o = mem_q[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_q <= '0;
      for (int i = 0; i < STACK_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      sp_q <= sp_d;
      for (int i = 0; i < STACK_DEPTH; i++) begin
        if (push_ok && sp_q == SP_W'(i)) mem_q[i] <= push_data_i;
      end
    end
  end

endmodule

// File: rtl/pc_stack_unit.sv
// Fetch-stage program counter with relative branch, call/return stack and sticky fault.
module pc_stack_unit
  import pc_pkg::*;
#(
  parameter int          ADDR_W      = 8,
  parameter int          STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             pc_enable,
  input  logic                             ld,
  input  logic                             rel,
  input  logic                             call,
  input  logic                             ret,
  input  logic [ADDR_W-1:0]                inp,
  output logic [ADDR_W-1:0]                out,
  output logic [$clog2(STACK_DEPTH+1)-1:0] sp,
  output logic                             stack_full,
  output logic                             stack_empty,
  output logic                             fault
);
  pc_op_e                    op;
  logic [ADDR_W-1:0]         pc_q, pc_d, pc_inc, pop_data;
  logic signed [ADDR_W-1:0]  offset;
  logic                      fault_q, fault_d, stack_err;

  assign op     = pc_decode(ret, call, ld, rel, pc_enable);
  assign pc_inc = pc_q + ADDR_W'(1);
  assign offset = $signed(inp);

  pc_ret_stack #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk         (clk),
    .rst         (reset),
    .push_i      (op == PC_CALL),
    .pop_i       (op == PC_RET),
    .push_data_i (pc_inc),
    .pop_data_o  (pop_data),
    .sp_o        (sp),
    .full_o      (stack_full),
    .empty_o     (stack_empty),
    .err_o       (stack_err)
  );

  // A refused call/return leaves the PC where it was.
  always_comb begin
    pc_d = pc_q;
    unique case (op)
      PC_INC:  pc_d = pc_inc;
      PC_REL:  pc_d = pc_q + $unsigned(offset);
      PC_LD:   pc_d = inp;
      PC_CALL: pc_d = stack_full  ? pc_q : inp;
      PC_RET:  pc_d = stack_empty ? pc_q : pop_data;
      default: pc_d = pc_q;
    endcase
  end

  assign fault_d = fault_q | stack_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= RESET_VEC;
      fault_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      fault_q <= fault_d;
    end
  end

  assign out   = pc_q;
  assign fault = fault_q;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Directed bench for pc_stack_unit at ADDR_W=8, STACK_DEPTH=4, RESET_VEC=0.
module tb_pc_stack_unit;
  logic       clk = 1'b0;
  logic       reset, pc_enable, ld, rel, call, ret;
  logic [7:0] inp;
  logic [7:0] out;
  logic [2:0] sp;
  logic       stack_full, stack_empty, fault;

  int total  = 0;
  int passed = 0;

  pc_stack_unit #(.ADDR_W(8), .STACK_DEPTH(4), .RESET_VEC(8'h00)) dut (
    .clk(clk), .reset(reset), .pc_enable(pc_enable), .ld(ld), .rel(rel),
    .call(call), .ret(ret), .inp(inp), .out(out), .sp(sp),
    .stack_full(stack_full), .stack_empty(stack_empty), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cmd(input logic r, input logic c, input logic l, input logic rl,
                     input logic e, input logic [7:0] d);
    ret = r; call = c; ld = l; rel = rl; pc_enable = e; inp = d;
    @(posedge clk); #1;
    ret = 0; call = 0; ld = 0; rel = 0; pc_enable = 0; inp = 8'h00;
  endtask

  task automatic chk_state(input string tag, input logic [7:0] e_out, input logic [2:0] e_sp,
                           input logic e_fault);
    check({tag, ".out"}, 32'(out), 32'(e_out));
    check({tag, ".sp"}, 32'(sp), 32'(e_sp));
    check({tag, ".fault"}, 32'(fault), 32'(e_fault));
  endtask

  initial begin
    reset = 1; pc_enable = 0; ld = 0; rel = 0; call = 0; ret = 0; inp = 8'h00;
    #2;
    chk_state("rst", 8'h00, 3'd0, 1'b0);
    check("rst.empty", 32'(stack_empty), 32'd1);
    check("rst.full", 32'(stack_full), 32'd0);
    @(negedge clk); reset = 0;

    for (int i = 1; i <= 5; i++) begin
      cmd(0, 0, 0, 0, 1, 8'h00);
      check("inc.out", 32'(out), 32'(i));
    end
    check("inc.sp", 32'(sp), 32'd0);
    check("inc.empty", 32'(stack_empty), 32'd1);

    cmd(0, 0, 1, 0, 0, 8'h18); check("ld", 32'(out), 32'h18);
    cmd(0, 0, 0, 0, 1, 8'h00);
    cmd(0, 0, 0, 0, 1, 8'h00);
    cmd(0, 0, 0, 0, 1, 8'h00); check("ld.inc3", 32'(out), 32'h1B);
    cmd(0, 0, 0, 0, 0, 8'h00); check("hold", 32'(out), 32'h1B);

    cmd(0, 1, 0, 0, 0, 8'h40); chk_state("call1", 8'h40, 3'd1, 1'b0);
    cmd(0, 0, 0, 0, 1, 8'h00);
    cmd(0, 0, 0, 0, 1, 8'h00); check("call1.inc", 32'(out), 32'h42);
    cmd(1, 0, 0, 0, 0, 8'h00); chk_state("ret1", 8'h1C, 3'd0, 1'b0);

    cmd(0, 0, 1, 0, 0, 8'h1B);
    cmd(0, 0, 0, 1, 0, 8'hFC); check("rel.neg", 32'(out), 32'h17);
    cmd(0, 0, 1, 0, 0, 8'hFF);
    cmd(0, 0, 0, 0, 1, 8'h00); check("inc.wrap", 32'(out), 32'h00);

    cmd(0, 1, 0, 0, 0, 8'h10); chk_state("nest1", 8'h10, 3'd1, 1'b0);
    cmd(0, 1, 0, 0, 0, 8'h20); chk_state("nest2", 8'h20, 3'd2, 1'b0);
    cmd(0, 1, 0, 0, 0, 8'h30); chk_state("nest3", 8'h30, 3'd3, 1'b0);
    cmd(0, 1, 0, 0, 0, 8'h40); chk_state("nest4", 8'h40, 3'd4, 1'b0);
    check("nest4.full", 32'(stack_full), 32'd1);
    cmd(0, 1, 0, 0, 0, 8'h80); chk_state("ovf", 8'h40, 3'd4, 1'b1);
    cmd(1, 0, 0, 0, 0, 8'h00); chk_state("pop4", 8'h31, 3'd3, 1'b1);
    cmd(1, 0, 0, 0, 0, 8'h00); chk_state("pop3", 8'h21, 3'd2, 1'b1);
    cmd(1, 0, 0, 0, 0, 8'h00); chk_state("pop2", 8'h11, 3'd1, 1'b1);
    cmd(1, 0, 0, 0, 0, 8'h00); chk_state("pop1", 8'h01, 3'd0, 1'b1);
    check("pop1.empty", 32'(stack_empty), 32'd1);
    cmd(1, 0, 0, 0, 0, 8'h00); chk_state("unf", 8'h01, 3'd0, 1'b1);

    cmd(0, 1, 0, 0, 0, 8'h50); chk_state("sim.call", 8'h50, 3'd1, 1'b1);
    cmd(1, 1, 0, 0, 1, 8'h60); chk_state("sim.ret", 8'h02, 3'd0, 1'b1);
    cmd(0, 0, 1, 0, 1, 8'h30); check("sim.ld", 32'(out), 32'h30);
    cmd(0, 0, 0, 1, 1, 8'h05); check("sim.rel", 32'(out), 32'h35);

    cmd(0, 1, 0, 0, 0, 8'h70);
    cmd(0, 1, 0, 0, 0, 8'h54);
    cmd(0, 0, 0, 0, 1, 8'h00); chk_state("pre_rst", 8'h55, 3'd2, 1'b1);
    #3 reset = 1;
    #1;
    chk_state("async_rst", 8'h00, 3'd0, 1'b0);
    check("async_rst.empty", 32'(stack_empty), 32'd1);
    check("async_rst.full", 32'(stack_full), 32'd0);
    @(posedge clk); @(negedge clk); reset = 0;
    cmd(0, 0, 0, 0, 1, 8'h00); chk_state("post_rst", 8'h01, 3'd0, 1'b0);
    cmd(1, 0, 0, 0, 0, 8'h00); chk_state("post_rst.unf", 8'h01, 3'd0, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pc_stack_unit.md
# pc_stack_unit

Parametrised program counter with relative branching and a hardware return-address stack for subroutine call/return. It replaces the fixed 8-bit increment/load counter in the fetch stage: it drives the instruction-memory address and takes control strobes from the decoder. Every PC update is single-cycle and registered. Stack overflow and underflow are detected and reported through a sticky fault flag.

## Interface
- `ADDR_W`, default 8: PC and address width in bits.
- `STACK_DEPTH`, default 4: number of return-address entries; must be ≥ 1.
- `RESET_VEC`, default 0: PC value loaded on reset.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high; overrides everything.
- `pc_enable`  in  1  increment PC by 1.
- `ld`  in  1  absolute load: PC ← `inp`.
- `rel`  in  1  relative branch: PC ← PC + sign-extended `inp`.
- `call`  in  1  push PC+1, then PC ← `inp`.
- `ret`  in  1  pop: PC ← top of stack.
- `inp`  in  ADDR_W  target address, or two's-complement branch offset.
- `out`  out  ADDR_W  current PC.
- `sp`  out  $clog2(STACK_DEPTH+1)  stack occupancy, 0..STACK_DEPTH.
- `stack_full`  out  1  `sp == STACK_DEPTH`.
- `stack_empty`  out  1  `sp == 0`.
- `fault`  out  1  sticky overflow/underflow flag.

## Operation
- Command priority when strobes overlap: `ret` > `call` > `ld` > `rel` > `pc_enable` > hold.
- Only the winning command takes effect. Losing strobes are ignored with no side effects.
- Hold: `out`, `sp` and stack contents are unchanged.
- Increment: `out` ← `out` + 1, modulo 2^ADDR_W. 0xFF → 0x00 at ADDR_W=8.
- Relative: `out` ← `out` + `inp`, with `inp` treated as signed. Result is modulo 2^ADDR_W; no overflow flag.
- Call, not full:
  - Stack[sp] ← (`out` + 1) mod 2^ADDR_W.
  - `sp` ← `sp` + 1; `out` ← `inp`.
- Call, full:
  - No push; `out` and `sp` hold.
  - `fault` ← 1.
- Return, not empty:
  - `out` ← stack[sp−1]; `sp` ← `sp` − 1.
- Return, empty:
  - `out` and `sp` hold.
  - `fault` ← 1.
- `fault` clears only on reset.
- `stack_full` and `stack_empty` are combinational decodes of `sp`.

## Timing
- All state updates on the rising edge of `clk`. Latency is 1 cycle from the command strobe to the new `out`.
- Back-to-back commands are supported every cycle, including call immediately followed by ret.
- Reset is asynchronous. Values while asserted, with no clock edge required:
  - `out` = RESET_VEC.
  - `sp` = 0.
  - `stack_empty` = 1, `stack_full` = 0.
  - `fault` = 0.
  - All stack entries = 0.
- Reset takes effect mid-operation from any state.
- Deassertion is sampled at a clock edge. The first command is accepted on the first rising edge after `reset` falls.
- Strobes are sampled at the edge only; no combinational path from any input to `out`.

## Structure
- Shared package `pc_pkg`:
  - enum `pc_op_e`: PC_HOLD, PC_INC, PC_REL, PC_LD, PC_CALL, PC_RET.
  - function `pc_decode(ret, call, ld, rel, pc_enable)` implementing the priority above.
- Sub-module `pc_ret_stack`:
  - Parametrised LIFO (ADDR_W, STACK_DEPTH) with push/pop, `sp`, full/empty.
  - Async reset clears all entries.
  - Refuses a push when full and a pop when empty; reports the refusal to the parent, which sets `fault`.
- Top level `pc_stack_unit`: PC register, next-PC multiplexer, sticky fault register.

## Test plan
All scenarios use ADDR_W=8, STACK_DEPTH=4, RESET_VEC=0.
- Reset, then `pc_enable` for 5 cycles → `out` steps 00, 01, 02, 03, 04, 05; `sp`=0; `stack_empty`=1.
- `ld` with `inp`=0x18 → `out`=0x18 next cycle; 3 increments → 0x1B. Then `rel` with `inp`=0xFC at 0x1B → 0x17. At 0xFF, increment → 0x00.
- At `out`=0x1B, `call` with `inp`=0x40 → `out`=0x40, `sp`=1. Two increments → 0x42. `ret` → `out`=0x1C, `sp`=0, `fault`=0.
- Nested calls:
  - 4 calls → `sp`=4, `stack_full`=1.
  - 5th call with `inp`=0x80 → `out` holds, `sp`=4, `fault`=1.
  - 4 returns unwind in LIFO order → `sp`=0.
  - Extra `ret` → `out` holds; `fault` stays 1.
- Simultaneous strobes: `ret`+`call`+`pc_enable` with `sp`=1 → pop only (`sp`=0, `out`=popped value). `ld`+`pc_enable` with `inp`=0x30 → `out`=0x30.
- Assert `reset` between clock edges with `sp`=2, `out`=0x55, `fault`=1 → immediately `out`=0x00, `sp`=0, `fault`=0. After release, `pc_enable` → 0x01 on the next edge.
